// File: rtl/cpu_pkg.sv
// Shared CPU definitions: opcode encodings used by fetch and the control
// decoder, plus the fetch sequencer state type.
package cpu_pkg;

  localparam logic [3:0] OP_LW  = 4'b0000;
  localparam logic [3:0] OP_SW  = 4'b0001;
  localparam logic [3:0] OP_BEQ = 4'b1011;
  localparam logic [3:0] OP_BNE = 4'b1100;
  localparam logic [3:0] OP_J   = 4'b1101;

  typedef enum logic [1:0] {
    S_REQ,
    S_WAIT,
    S_OUT,
    S_RES
  } fetch_state_t;

  // Control-flow opcodes stall fetch until the decoder resolves them.
  function automatic logic is_ctrl_op(input logic [3:0] op);
    return (op == OP_BEQ) || (op == OP_BNE) || (op == OP_J);
  endfunction

endpackage

// File: rtl/next_pc_calc.sv
// Next-PC arithmetic: sequential step, jump target and PC-relative branch.
// All sums wrap modulo 2^ADDR_W by construction of the adder widths.
module next_pc_calc #(
  parameter int ADDR_W  = 16,
  parameter int INSTR_W = 16
) (
  input  logic [ADDR_W-1:0]  pc_i,
  input  logic [INSTR_W-1:0] instr_i,
  input  logic               jump_i,
  input  logic               beq_i,
  input  logic               bne_i,
  input  logic               zero_i,
  output logic [ADDR_W-1:0]  next_pc_o
);

  logic [ADDR_W-1:0] pc_plus2;
  logic [ADDR_W-1:0] jump_tgt;
  logic [ADDR_W-1:0] br_off;
  logic [ADDR_W-1:0] br_tgt;
  logic              br_taken;
  logic              unused_opcode;

  // Opcode bits are decoded elsewhere; only the immediate fields matter here.
  assign unused_opcode = ^instr_i[INSTR_W-1:12];

  assign pc_plus2 = pc_i + ADDR_W'(2);
  // Jump stays inside the 8 KiB region of the following instruction.
  assign jump_tgt = {pc_plus2[ADDR_W-1:13], instr_i[11:0], 1'b0};
  assign br_off   = {{(ADDR_W-7){instr_i[5]}}, instr_i[5:0], 1'b0};
  assign br_tgt   = pc_plus2 + br_off;
  assign br_taken = (beq_i & zero_i) | (bne_i & ~zero_i);

  // Select next PC; jump has priority over a taken branch.
  always_comb begin
    next_pc_o = pc_plus2;
    if (jump_i) begin
      next_pc_o = jump_tgt;
    end else if (br_taken) begin
      next_pc_o = br_tgt;
    end
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch sequencer: one outstanding memory request, registered
// valid/ready output to decode, and a stall on control-flow instructions
// until the decoder reports the resolution.
//
// state  | meaning
// S_REQ  | issue one-cycle imem_req at PC
// S_WAIT | waiting for imem_valid
// S_OUT  | instruction held on out_* until accepted
// S_RES  | control-flow instruction accepted, waiting for resolve_valid
module instr_fetch_unit
  import cpu_pkg::*;
#(
  parameter int              ADDR_W   = 16,
  parameter int              INSTR_W  = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               rst,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic [INSTR_W-1:0] imem_rdata,
  input  logic               imem_valid,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [INSTR_W-1:0] out_instr,
  output logic [3:0]         out_opcode,
  output logic [ADDR_W-1:0]  out_pc,
  input  logic               resolve_valid,
  input  logic               jump,
  input  logic               beq,
  input  logic               bne,
  input  logic               zero
);

  fetch_state_t       state_q, state_d;
  logic [ADDR_W-1:0]  pc_q, pc_d;
  logic               req_q, req_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic               valid_q, valid_d;
  logic [INSTR_W-1:0] instr_q, instr_d;
  logic [ADDR_W-1:0]  opc_pc_q, opc_pc_d;
  logic [ADDR_W-1:0]  next_pc;
  logic               in_res;

  // Decoder flags only steer the PC while resolving; elsewhere next_pc is PC+2.
  assign in_res = (state_q == S_RES);

  next_pc_calc #(
    .ADDR_W (ADDR_W),
    .INSTR_W(INSTR_W)
  ) u_next_pc (
    .pc_i     (pc_q),
    .instr_i  (instr_q),
    .jump_i   (jump & in_res),
    .beq_i    (beq & in_res),
    .bne_i    (bne & in_res),
    .zero_i   (zero),
    .next_pc_o(next_pc)
  );

  // Next-state and registered-output logic.
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    req_d    = 1'b0;
    addr_d   = addr_q;
    valid_d  = valid_q;
    instr_d  = instr_q;
    opc_pc_d = opc_pc_q;
    case (state_q)
      S_REQ: begin
        // Out of reset the request is not yet raised; raise it here once.
        if (req_q) begin
          state_d = S_WAIT;
        end else begin
          req_d  = 1'b1;
          addr_d = pc_q;
        end
      end
      S_WAIT: begin
        if (imem_valid) begin
          instr_d  = imem_rdata;
          opc_pc_d = pc_q;
          valid_d  = 1'b1;
          state_d  = S_OUT;
        end
      end
      S_OUT: begin
        if (out_ready) begin
          valid_d = 1'b0;
          if (is_ctrl_op(instr_q[INSTR_W-1 -: 4])) begin
            state_d = S_RES;
          end else begin
            // Raise the next request directly to keep a 3-cycle cadence.
            pc_d    = next_pc;
            addr_d  = next_pc;
            req_d   = 1'b1;
            state_d = S_REQ;
          end
        end
      end
      S_RES: begin
        if (resolve_valid) begin
          pc_d    = next_pc;
          addr_d  = next_pc;
          req_d   = 1'b1;
          state_d = S_REQ;
        end
      end
      default: begin
        state_d = S_REQ;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_REQ;
      pc_q     <= RESET_PC;
      req_q    <= 1'b0;
      addr_q   <= RESET_PC;
      valid_q  <= 1'b0;
      instr_q  <= '0;
      opc_pc_q <= RESET_PC;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      req_q    <= req_d;
      addr_q   <= addr_d;
      valid_q  <= valid_d;
      instr_q  <= instr_d;
      opc_pc_q <= opc_pc_d;
    end
  end

  assign imem_req   = req_q;
  assign imem_addr  = addr_q;
  assign out_valid  = valid_q;
  assign out_instr  = instr_q;
  assign out_opcode = instr_q[INSTR_W-1 -: 4];
  assign out_pc     = opc_pc_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: memory responder, architectural PC model with a
// per-cycle compare process, and a directed program walk with literal targets.
module tb_instr_fetch_unit;

  localparam logic [15:0] RESET_PC = 16'h0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic [15:0] imem_rdata = '0;
  logic        imem_valid = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] out_instr;
  logic [3:0]  out_opcode;
  logic [15:0] out_pc;
  logic        resolve_valid = 1'b0;
  logic        jump = 1'b0;
  logic        beq = 1'b0;
  logic        bne = 1'b0;
  logic        zero = 1'b0;

  always #5 clk = ~clk;

  instr_fetch_unit #(
    .ADDR_W  (16),
    .INSTR_W (16),
    .RESET_PC(RESET_PC)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_rdata   (imem_rdata),
    .imem_valid   (imem_valid),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_instr    (out_instr),
    .out_opcode   (out_opcode),
    .out_pc       (out_pc),
    .resolve_valid(resolve_valid),
    .jump         (jump),
    .beq          (beq),
    .bne          (bne),
    .zero         (zero)
  );

  int errors = 0;
  int checks = 0;

  logic [15:0] mem [logic [15:0]];

  // Unprogrammed locations read as opcode 0 (plain sequential instruction).
  function automatic logic [15:0] mem_rd(input logic [15:0] a);
    if (mem.exists(a)) return mem[a];
    return {4'h0, a[11:0]};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Instruction memory: configurable latency, one outstanding request.
  int          mem_lat = 1;
  int          mcnt = 0;
  logic [15:0] maddr = '0;
  logic        spur = 1'b0;
  always @(negedge clk) begin
    imem_valid = 1'b0;
    if (rst) begin
      mcnt = 0;
    end else begin
      if (mcnt > 0) begin
        mcnt--;
        if (mcnt == 0) begin
          imem_valid = 1'b1;
          imem_rdata = mem_rd(maddr);
        end
      end
      if (spur && !imem_valid) begin
        imem_valid = 1'b1;
        imem_rdata = 16'hFFFF;
      end
      if (imem_req) begin
        maddr = imem_addr;
        mcnt  = mem_lat;
      end
    end
  end

  // Architectural model: PC of the instruction being fetched / presented,
  // and the control-flow instruction awaiting resolution.
  logic [15:0] exp_pc = RESET_PC;
  bit          pend = 1'b0;
  logic [15:0] pend_instr = '0;
  bit          prev_hold = 1'b0;
  int          req_count = 0;
  logic [15:0] m_word;
  logic [15:0] m_pc2;
  int          m_off;

  always @(negedge clk) begin
    if (rst) begin
      exp_pc    = RESET_PC;
      pend      = 1'b0;
      prev_hold = 1'b0;
      chk("rst_req", imem_req, 0);
      chk("rst_addr", imem_addr, RESET_PC);
      chk("rst_valid", out_valid, 0);
      chk("rst_instr", out_instr, 0);
      chk("rst_opcode", out_opcode, 0);
      chk("rst_pc", out_pc, RESET_PC);
    end else begin
      m_word = mem_rd(exp_pc);
      if (imem_req) begin
        req_count++;
        chk("fetch_addr", imem_addr, exp_pc);
        chk("req_while_busy", {out_valid, pend}, 0);
      end
      if (prev_hold) chk("valid_held", out_valid, 1);
      if (out_valid) begin
        chk("out_instr", out_instr, m_word);
        chk("out_opcode", out_opcode, m_word >> 12);
        chk("out_pc", out_pc, exp_pc);
      end
      prev_hold = out_valid && !out_ready;
      if (pend && resolve_valid) begin
        m_pc2 = exp_pc + 16'd2;
        m_off = pend_instr[5] ? int'(pend_instr[5:0]) - 64 : int'(pend_instr[5:0]);
        if (jump)
          exp_pc = {m_pc2[15:13], pend_instr[11:0], 1'b0};
        else if ((beq && zero) || (bne && !zero))
          exp_pc = 16'(int'(m_pc2) + 2 * m_off);
        else
          exp_pc = m_pc2;
        pend = 1'b0;
      end else if (out_valid && out_ready) begin
        if (m_word[15:12] == 4'hB || m_word[15:12] == 4'hC || m_word[15:12] == 4'hD) begin
          pend       = 1'b1;
          pend_instr = m_word;
        end else begin
          exp_pc = exp_pc + 16'd2;
        end
      end
    end
  end

  int req_gap = 0;

  task automatic expect_req(input string name, input logic [15:0] a);
    int n = 0;
    @(negedge clk);
    while (!imem_req && n < 60) begin
      @(negedge clk);
      n++;
    end
    req_gap = n + 1;
    chk({name, "_seen"}, imem_req, 1);
    chk(name, imem_addr, a);
  endtask

  task automatic resolve(input logic j, input logic b, input logic n_, input logic z, input int delay);
    int k = 0;
    @(posedge clk); #1;
    while (!pend && k < 60) begin
      @(posedge clk); #1;
      k++;
    end
    chk("pend_seen", pend, 1);
    repeat (delay) begin
      @(posedge clk); #1;
    end
    resolve_valid = 1'b1; jump = j; beq = b; bne = n_; zero = z;
    @(posedge clk); #1;
    resolve_valid = 1'b0; jump = 1'b0; beq = 1'b0; bne = 1'b0; zero = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  int base;
  int n;

  initial begin
    mem[16'h0000] = 16'h2123;
    mem[16'h0002] = 16'hB03C;  // BEQ -8 -> 0xFFFC when taken
    mem[16'hFFFC] = 16'hD000;  // J -> 0xE000
    mem[16'hE000] = 16'hD123;  // J -> 0xE246
    mem[16'hE246] = 16'hDFFF;  // J -> 0xFFFE
    mem[16'h0004] = 16'hD008;  // J -> 0x0010
    mem[16'h0010] = 16'hB03E;
    mem[16'h0012] = 16'hD010;  // J -> 0x0020
    mem[16'h0020] = 16'hC005;
    mem[16'h002C] = 16'hA000;
    mem[16'h002E] = 16'hE000;
    mem[16'h0030] = 16'hF000;
    mem[16'h0032] = 16'hC005;
    mem[16'h0034] = 16'hD000;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_addr_lit", imem_addr, 16'h0000);
    chk("reset_valid_lit", out_valid, 0);
    @(posedge clk); #1;
    rst = 1'b0;

    expect_req("first_fetch", 16'h0000);
    chk("first_req_gap", req_gap, 2);
    n = 0;
    while (!out_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("mem1_latency", n, 2);
    chk("first_opcode_lit", out_opcode, 4'h2);
    chk("first_pc_lit", out_pc, 16'h0000);

    // Backpressure with a stray memory strobe that must be ignored.
    base = req_count;
    @(posedge clk); #1; spur = 1'b1;
    @(posedge clk); #1; spur = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
    end
    chk("bp_no_req", req_count - base, 0);
    chk("bp_stable_lit", out_instr, 16'h2123);
    chk("bp_valid_lit", out_valid, 1);
    out_ready = 1'b1;
    expect_req("after_accept", 16'h0002);

    resolve(1'b0, 1'b1, 1'b0, 1'b1, 0);
    expect_req("beq_wrap_fffc", 16'hFFFC);
    chk("res_to_req", req_gap, 1);
    resolve(1'b1, 1'b0, 1'b0, 1'b0, 0);
    expect_req("j_to_e000", 16'hE000);
    resolve(1'b1, 1'b1, 1'b0, 1'b1, 0);
    expect_req("j_wins_e246", 16'hE246);
    resolve(1'b1, 1'b0, 1'b0, 1'b0, 0);
    expect_req("j_to_fffe", 16'hFFFE);
    expect_req("wrap_0000", 16'h0000);
    chk("seq_throughput", req_gap, 3);
    expect_req("seq_0002", 16'h0002);
    resolve(1'b0, 1'b1, 1'b0, 1'b0, 0);
    expect_req("beq_nt_0004", 16'h0004);

    mem_lat = 3;
    resolve(1'b1, 1'b0, 1'b0, 1'b0, 0);
    expect_req("j_to_0010", 16'h0010);
    resolve(1'b0, 1'b1, 1'b0, 1'b1, 2);
    expect_req("beq_taken_000e", 16'h000E);
    expect_req("seq_0010", 16'h0010);
    resolve(1'b0, 1'b1, 1'b0, 1'b0, 0);
    expect_req("beq_nt_0012", 16'h0012);
    resolve(1'b1, 1'b0, 1'b0, 1'b0, 0);
    expect_req("j_to_0020", 16'h0020);
    resolve(1'b0, 1'b0, 1'b1, 1'b0, 4);
    expect_req("bne_taken_002c", 16'h002C);

    // Stray resolve while fetching a sequential instruction.
    mem_lat = 1;
    @(posedge clk); #1;
    resolve_valid = 1'b1; jump = 1'b1;
    @(posedge clk); #1;
    resolve_valid = 1'b0; jump = 1'b0;
    expect_req("op_a_seq", 16'h002E);
    expect_req("op_e_seq", 16'h0030);
    expect_req("op_f_seq", 16'h0032);
    resolve(1'b0, 1'b0, 1'b1, 1'b1, 0);
    expect_req("bne_nt_0034", 16'h0034);

    // Reset while waiting for resolution.
    n = 0;
    @(posedge clk); #1;
    while (!pend && n < 60) begin
      @(posedge clk); #1;
      n++;
    end
    chk("pend_before_rst", pend, 1);
    repeat (2) begin
      @(posedge clk); #1;
    end
    rst = 1'b1;
    @(negedge clk);
    chk("rst_in_res_valid", out_valid, 0);
    chk("rst_in_res_instr", out_instr, 16'h0000);
    @(posedge clk); #1;
    rst = 1'b0;
    expect_req("after_reset", RESET_PC);

    repeat (4) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
